// File: rtl/alu_logical_checker.sv
// ----------------------------------------------------------------------------
// alu_logical_checker
// Scoreboard for an alu_logical instance. It checks the observed result of
// each accepted vector against a built-in reference model, tallies
// pass/fail/illegal results per run and captures the first mismatch.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   start                        one-cycle pulse, begins a run from IDLE/DONE
//   in_valid / in_ready          vector handshake (accept = valid && ready)
//   in1, in2, sel2..sel0, out    operands, op select, observed ALU result
//   pass_cnt, fail_cnt,
//   illegal_cnt                  saturating per-run tallies
//   err                          sticky mismatch flag for the current run
//   fail_sel, fail_exp, fail_got first-mismatch capture
//   busy, done                   run in progress / run complete
// ----------------------------------------------------------------------------
module alu_logical_checker #(
    parameter int unsigned NUM_VEC = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in1,
    input  logic [31:0]      in2,
    input  logic             sel2,
    input  logic             sel1,
    input  logic             sel0,
    input  logic [31:0]      out,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             err,
    output logic [2:0]       fail_sel,
    output logic [31:0]      fail_exp,
    output logic [31:0]      fail_got,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned ACC_W  = 16;

    localparam logic [ACC_W-1:0] NUM_VEC_C = ACC_W'(NUM_VEC);

    // State encoding chosen so busy/done are direct state register bits.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic [ACC_W-1:0]  acc_cnt;
    logic              stg_valid;
    logic [SEL_W-1:0]  stg_sel;
    logic [DATA_W-1:0] stg_in1;
    logic [DATA_W-1:0] stg_in2;
    logic [DATA_W-1:0] stg_out;

    logic [DATA_W-1:0] exp_c;
    logic              legal_c;
    logic              start_run_c;
    logic              accept_c;
    logic              last_retire_c;

    assign busy = state[0];
    assign done = state[1];

    assign start_run_c   = start && (state != RUN);
    assign accept_c      = in_valid && in_ready;
    // acc_cnt only reaches NUM_VEC on the final accept, so a full stage
    // at that point holds the last vector of the run.
    assign last_retire_c = stg_valid && (acc_cnt == NUM_VEC_C);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_retire_c) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Reference model of alu_logical evaluated on the compare stage
    always_comb begin
        exp_c   = '0;
        legal_c = 1'b1;
        case (stg_sel)
            3'b000:  exp_c = stg_in1 & stg_in2;
            3'b001:  exp_c = stg_in1 | stg_in2;
            3'b010:  exp_c = stg_in1 ^ stg_in2;
            3'b110:  exp_c = stg_in1 << stg_in2[4:0];
            3'b100:  exp_c = DATA_W'($unsigned($signed(stg_in1) >>> stg_in2[4:0]));
            3'b101:  exp_c = stg_in1 >> stg_in2[4:0];
            default: legal_c = 1'b0;
        endcase
    end

    // Accept/compare pipeline, tallies and first-mismatch capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready    <= 1'b0;
            acc_cnt     <= '0;
            stg_valid   <= 1'b0;
            stg_sel     <= '0;
            stg_in1     <= '0;
            stg_in2     <= '0;
            stg_out     <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            illegal_cnt <= '0;
            err         <= 1'b0;
            fail_sel    <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
        end else if (start_run_c) begin
            in_ready    <= (NUM_VEC_C != '0);
            acc_cnt     <= '0;
            stg_valid   <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            illegal_cnt <= '0;
            err         <= 1'b0;
            fail_sel    <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
        end else begin
            stg_valid <= accept_c;
            if (accept_c) begin
                stg_sel  <= {sel2, sel1, sel0};
                stg_in1  <= in1;
                stg_in2  <= in2;
                stg_out  <= out;
                acc_cnt  <= acc_cnt + ACC_W'(1);
                in_ready <= ((acc_cnt + ACC_W'(1)) < NUM_VEC_C);
            end

            if (stg_valid) begin
                if (!legal_c) begin
                    if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
                end else if (stg_out == exp_c) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                    err <= 1'b1;
                    if (!err) begin
                        fail_sel <= stg_sel;
                        fail_exp <= exp_c;
                        fail_got <= stg_out;
                    end
                end
            end
        end
    end

endmodule
